// File: rtl/lcd_panel_seq.sv
// LCD panel power-up sequencer: strap detect, decode, driver release,
// display enable after stable frames, frame watchdog and re-detect.
module lcd_panel_seq #(
  parameter int SETTLE_CYCLES     = 1000,
  parameter int SAMPLE_GAP        = 16,
  parameter int MAX_RETRY         = 3,
  parameter int DISP_DELAY_FRAMES = 2,
  parameter int FRAME_TIMEOUT     = 2000000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [2:0]  strap_in,
  input  logic        lcd_vs,
  input  logic        redetect,
  output logic        bus_oe,
  output logic [15:0] lcd_id,
  output logic [10:0] h_disp,
  output logic [10:0] v_disp,
  output logic [1:0]  pclk_sel,
  output logic        cfg_valid,
  output logic        drv_rst,
  output logic        lcd_disp,
  output logic [1:0]  fault
);

  typedef enum logic [2:0] {
    SETTLE, SAMPLE1, GAP, SAMPLE2,
    CONFIG, WAIT_FRM, ON, HALT
  } state_t;

  localparam int CMAX = (SETTLE_CYCLES > SAMPLE_GAP) ?
                        SETTLE_CYCLES : SAMPLE_GAP;
  localparam int CW = $clog2(CMAX + 1);
  localparam int WW = $clog2(FRAME_TIMEOUT + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam int FW = $clog2(DISP_DELAY_FRAMES + 1);

  localparam logic [CW-1:0] SETTLE_END = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_END    = CW'(SAMPLE_GAP - 1);
  localparam logic [WW-1:0] WDOG_END   = WW'(FRAME_TIMEOUT - 1);
  localparam logic [RW-1:0] RETRY_LIM  = RW'(MAX_RETRY);
  localparam logic [FW-1:0] FRM_END    = FW'(DISP_DELAY_FRAMES - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [WW-1:0] wdog;
  logic [RW-1:0] retry;
  logic [FW-1:0] frm;
  logic [2:0]    s1;
  logic [2:0]    vs_sync;
  logic          vs_pulse;
  logic          timeout;

  logic          dec_ok;
  logic [15:0]   dec_id;
  logic [10:0]   dec_h;
  logic [10:0]   dec_v;
  logic [1:0]    dec_sel;

  always_comb begin
    dec_ok  = 1'b1;
    dec_id  = 16'h4342;
    dec_h   = 11'd480;
    dec_v   = 11'd272;
    dec_sel = 2'd0;
    case (strap_in)
      3'b000: dec_ok = 1'b1;
      3'b001: begin
        dec_id  = 16'h7084;
        dec_h   = 11'd800;
        dec_v   = 11'd480;
        dec_sel = 2'd1;
      end
      3'b010: begin
        dec_id  = 16'h7016;
        dec_h   = 11'd1024;
        dec_v   = 11'd600;
        dec_sel = 2'd2;
      end
      3'b100: begin
        dec_id  = 16'h4384;
        dec_h   = 11'd800;
        dec_v   = 11'd480;
        dec_sel = 2'd1;
      end
      3'b101: begin
        dec_id  = 16'h1018;
        dec_h   = 11'd1280;
        dec_v   = 11'd800;
        dec_sel = 2'd3;
      end
      default: dec_ok = 1'b0;
    endcase
  end

  // Two-flop synchronizer plus edge register: pin to pulse is 3 clocks
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      vs_sync  <= '0;
      vs_pulse <= 1'b0;
    end else begin
      vs_sync  <= {vs_sync[1:0], lcd_vs};
      vs_pulse <= vs_sync[1] & ~vs_sync[2];
    end
  end

  assign timeout = !vs_pulse && (wdog == WDOG_END);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= SETTLE;
      cnt       <= '0;
      wdog      <= '0;
      retry     <= '0;
      frm       <= '0;
      s1        <= '0;
      bus_oe    <= 1'b0;
      lcd_id    <= '0;
      h_disp    <= '0;
      v_disp    <= '0;
      pclk_sel  <= '0;
      cfg_valid <= 1'b0;
      drv_rst   <= 1'b1;
      lcd_disp  <= 1'b0;
      fault     <= 2'd0;
    end else begin
      case (state)
        SETTLE:
          if (cnt == SETTLE_END) begin
            cnt   <= '0;
            state <= SAMPLE1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        SAMPLE1: begin
          s1    <= strap_in;
          state <= GAP;
        end
        GAP:
          if (cnt == GAP_END) begin
            cnt   <= '0;
            state <= SAMPLE2;
          end else begin
            cnt <= cnt + CW'(1);
          end
        SAMPLE2:
          if (strap_in == s1 && dec_ok) begin
            lcd_id    <= dec_id;
            h_disp    <= dec_h;
            v_disp    <= dec_v;
            pclk_sel  <= dec_sel;
            cfg_valid <= 1'b1;
            state     <= CONFIG;
          end else if (retry == RETRY_LIM) begin
            lcd_id    <= 16'h4342;
            h_disp    <= 11'd480;
            v_disp    <= 11'd272;
            pclk_sel  <= 2'd0;
            cfg_valid <= 1'b1;
            fault     <= 2'd1;
            state     <= CONFIG;
          end else begin
            retry <= retry + RW'(1);
            state <= SETTLE;
          end
        CONFIG: begin
          drv_rst <= 1'b0;
          bus_oe  <= 1'b1;
          wdog    <= '0;
          frm     <= '0;
          state   <= WAIT_FRM;
        end
        WAIT_FRM, ON:
          if (timeout) begin
            drv_rst  <= 1'b1;
            lcd_disp <= 1'b0;
            bus_oe   <= 1'b0;
            fault    <= 2'd2;
            state    <= HALT;
          end else if (redetect) begin
            drv_rst   <= 1'b1;
            lcd_disp  <= 1'b0;
            bus_oe    <= 1'b0;
            cfg_valid <= 1'b0;
            fault     <= 2'd0;
            retry     <= '0;
            cnt       <= '0;
            state     <= SETTLE;
          end else begin
            wdog <= vs_pulse ? '0 : wdog + WW'(1);
            if (state == WAIT_FRM && vs_pulse) begin
              if (frm == FRM_END) begin
                lcd_disp <= 1'b1;
                state    <= ON;
              end else begin
                frm <= frm + FW'(1);
              end
            end
          end
        HALT: state <= HALT;
        default: state <= SETTLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_panel_seq.sv
// Directed bench for lcd_panel_seq: scoreboard of expected panel configs,
// checked when cfg_valid rises; timing, fallback, halt and reset checks.
module tb_lcd_panel_seq;

  localparam int S    = 20;
  localparam int G    = 4;
  localparam int MR   = 3;
  localparam int DF   = 2;
  localparam int FT   = 300;
  localparam int PASS = S + G + 2;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [2:0]  strap_in = 3'b000;
  logic        lcd_vs = 1'b0;
  logic        redetect = 1'b0;
  logic        bus_oe;
  logic [15:0] lcd_id;
  logic [10:0] h_disp;
  logic [10:0] v_disp;
  logic [1:0]  pclk_sel;
  logic        cfg_valid;
  logic        drv_rst;
  logic        lcd_disp;
  logic [1:0]  fault;

  typedef struct packed {
    logic [15:0] id;
    logic [10:0] h;
    logic [10:0] v;
    logic [1:0]  sel;
    logic [1:0]  flt;
  } cfg_t;

  cfg_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   t0;
  int   last_edge;

  lcd_panel_seq #(
    .SETTLE_CYCLES(S), .SAMPLE_GAP(G), .MAX_RETRY(MR),
    .DISP_DELAY_FRAMES(DF), .FRAME_TIMEOUT(FT)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .strap_in(strap_in),
    .lcd_vs(lcd_vs), .redetect(redetect), .bus_oe(bus_oe),
    .lcd_id(lcd_id), .h_disp(h_disp), .v_disp(v_disp),
    .pclk_sel(pclk_sel), .cfg_valid(cfg_valid), .drv_rst(drv_rst),
    .lcd_disp(lcd_disp), .fault(fault)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic cfg_t model(input logic [2:0] s, input logic fb);
    cfg_t c;
    c = '{16'h4342, 11'd480, 11'd272, 2'd0, 2'd0};
    if (fb) c.flt = 2'd1;
    else begin
      case (s)
        3'b001: c = '{16'h7084, 11'd800, 11'd480, 2'd1, 2'd0};
        3'b010: c = '{16'h7016, 11'd1024, 11'd600, 2'd2, 2'd0};
        3'b100: c = '{16'h4384, 11'd800, 11'd480, 2'd1, 2'd0};
        3'b101: c = '{16'h1018, 11'd1280, 11'd800, 2'd3, 2'd0};
        default: c = c;
      endcase
    end
    return c;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic do_reset(input string tag);
    sys_rst = 1'b1;
    tick(1);
    chk({tag, "_rstvals"},
        {bus_oe, lcd_id, h_disp, v_disp, pclk_sel,
         cfg_valid, drv_rst, lcd_disp, fault},
        {1'b0, 16'h0, 11'h0, 11'h0, 2'b0, 1'b0, 1'b1, 1'b0, 2'b0});
    tick(1);
    sys_rst = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_cfg(input string tag, input int want, input int start);
    int n = 0;
    cfg_t e;
    while (!cfg_valid && n < 2000) begin
      tick(1);
      n++;
    end
    chk({tag, "_seen"}, cfg_valid, 1);
    e = exp_q.pop_front();
    chk({tag, "_id"}, lcd_id, e.id);
    chk({tag, "_h"}, h_disp, e.h);
    chk({tag, "_v"}, v_disp, e.v);
    chk({tag, "_sel"}, pclk_sel, e.sel);
    chk({tag, "_fault"}, fault, e.flt);
    chk({tag, "_lat"}, cyc - start, want);
    chk({tag, "_cfgcyc"}, {drv_rst, bus_oe}, 2'b10);
    tick(1);
    chk({tag, "_release"}, {drv_rst, bus_oe, cfg_valid}, 3'b011);
  endtask

  task automatic display_seq(input string tag);
    lcd_vs = 1'b1;
    tick(3);
    lcd_vs = 1'b0;
    tick(3);
    chk({tag, "_disp_f1"}, lcd_disp, 0);
    lcd_vs = 1'b1;
    last_edge = cyc;
    tick(3);
    chk({tag, "_disp_early"}, lcd_disp, 0);
    tick(1);
    chk({tag, "_disp_on"}, lcd_disp, 1);
    lcd_vs = 1'b0;
  endtask

  initial begin
    int n;
    int el;

    // A: strap 001 from reset, full sequence
    strap_in = 3'b001;
    exp_q.push_back(model(3'b001, 1'b0));
    do_reset("a");
    wait_cfg("a", PASS, t0);
    display_seq("a");

    // B: redetect in ON with strap 010; a second redetect in SETTLE is ignored
    strap_in = 3'b010;
    exp_q.push_back(model(3'b010, 1'b0));
    redetect = 1'b1;
    t0 = cyc;
    tick(1);
    redetect = 1'b0;
    chk("b_drop", {lcd_disp, cfg_valid, drv_rst, bus_oe}, 4'b0010);
    tick(5);
    redetect = 1'b1;
    tick(1);
    redetect = 1'b0;
    wait_cfg("b", PASS + 1, t0);
    display_seq("b");

    // B2: vs stuck low in ON -> HALT
    n = 0;
    while (fault !== 2'd2 && n < 2 * FT) begin
      tick(1);
      n++;
    end
    el = cyc - last_edge;
    chk("halt_lat", (el >= FT && el <= FT + 6), 1);
    chk("halt_outs", {lcd_disp, drv_rst, bus_oe, cfg_valid, fault},
        {1'b0, 1'b1, 1'b0, 1'b1, 2'd2});
    lcd_vs = 1'b1;
    tick(4);
    lcd_vs = 1'b0;
    redetect = 1'b1;
    tick(1);
    redetect = 1'b0;
    tick(10);
    chk("halt_sticky", {lcd_disp, drv_rst, bus_oe, cfg_valid, fault},
        {1'b0, 1'b1, 1'b0, 1'b1, 2'd2});

    // C: strap changes between samples on first pass -> one retry
    strap_in = 3'b000;
    exp_q.push_back(model(3'b101, 1'b0));
    do_reset("c");
    tick(S + 3);
    strap_in = 3'b101;
    wait_cfg("c", 2 * PASS, t0);

    // D: invalid strap; reset during GAP of pass 3 clears retry
    strap_in = 3'b111;
    exp_q.push_back(model(3'b111, 1'b1));
    do_reset("d0");
    tick(2 * PASS + S + 3);
    do_reset("d1");
    wait_cfg("d", (MR + 1) * PASS, t0);
    display_seq("d");
    chk("d_fault_on", fault, 2'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
